button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//   Sits directly downstream of Debounce_Filter and consumes its clean o_debounced level.
//   Classifies each press of a single button as short or long. While a long press is
//   held, it emits periodic auto-repeat pulses. It also maintains a wrapping count of
//   classified presses. All outputs are registered, so the block drives LEDs and
//   7-seg logic directly.
// PARAMETERS
//   LONG_LIMIT   25_000_000  consecutive high samples that make a press "long" (>=2)
//   REPEAT_LIMIT 5_000_000   high samples between auto-repeat pulses in LONG; 0 = repeat disabled
//   COUNT_WIDTH  8           width of o_press_count
// PORTS
//   i_clk          in   1            system clock
//   i_rst          in   1            reset, synchronous, active-high
//   i_debounced    in   1            debounced button level (1 = pressed), synchronous to i_clk
//   o_short_press  out  1            1-cycle pulse: released before LONG_LIMIT high samples
//   o_long_press   out  1            1-cycle pulse: LONG_LIMIT-th consecutive high sample reached
//   o_repeat       out  1            1-cycle pulse every REPEAT_LIMIT high samples while in LONG
//   o_held         out  1            level: state is HELD or LONG
//   o_press_count  out  COUNT_WIDTH  number of short+long events, wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//   - Reset
//     - i_rst is sampled on the i_clk rising edge and dominates all other inputs.
//     - Reset sets state=ARM, hold counter=0, and every output to 0 (including o_press_count).
//   - States: ARM, IDLE, HELD, LONG. Each transition below happens at one clock edge
//     and is based on the sampled i_debounced.
//     - ARM:  i_debounced=0 -> IDLE; i_debounced=1 -> stay in ARM.
//             Effect: a button already down at reset, or held through reset, is never classified.
//     - IDLE: i_debounced=1 -> HELD, cnt<=1.
//     - HELD: i_debounced=0 -> IDLE, o_short_press<=1.
//             i_debounced=1 and cnt==LONG_LIMIT-1 -> LONG, o_long_press<=1, cnt<=0.
//             Otherwise cnt<=cnt+1.
//     - LONG: i_debounced=0 -> IDLE, with no pulse.
//             i_debounced=1, REPEAT_LIMIT!=0 and cnt==REPEAT_LIMIT-1 -> o_repeat<=1, cnt<=0.
//             Otherwise cnt<=cnt+1 (saturates at its maximum when repeat is disabled).
//   - Timing and pulse rules
//     - A press of N high samples, 1<=N<=LONG_LIMIT-1, gives o_short_press in the cycle
//       after the first low sample.
//     - o_long_press is visible in the cycle after the LONG_LIMIT-th high sample.
//     - Pulses are exactly 1 cycle wide. At most one of short/long/repeat is high in any cycle.
//   - o_press_count
//     - Increments in the same cycle that o_short_press or o_long_press asserts.
//     - o_repeat never changes it. 2^COUNT_WIDTH-1 wraps to 0.
//   - o_held is registered: 1 exactly while state is HELD or LONG.
//   - Hold counter width is $clog2(max(LONG_LIMIT,REPEAT_LIMIT)+1). It never wraps.
//   - Illegal state encodings recover to ARM.
// STRUCTURE
//   - Shared package button_pkg:
//     - typedef enum logic [1:0] {ARM, IDLE, HELD, LONG} press_state_t
//     - helper function max_int() used for the counter width
//   - One sub-module, hold_timer:
//     - parameterised up-counter with synchronous clear, increment enable and saturation
//     - exposes its count value
//     - the FSM owns the terminal-value compares
//   - The top level holds the FSM and output registers only.
// TESTING  (bench: LONG_LIMIT=8, REPEAT_LIMIT=4, COUNT_WIDTH=2, clock period 4)
//   1. Idle low 3 cycles, high 3 samples, low.
//      -> o_short_press high for exactly 1 cycle.
//      -> o_press_count 0->1.
//      -> o_long_press and o_repeat never assert.
//      -> o_held high for 3 cycles.
//   2. High 7 samples then low -> one short pulse.
//      High 8 samples then low -> o_long_press in the cycle after the 8th sample,
//      no short pulse on release.
//      -> o_press_count=2 at the end.
//   3. High 16 samples.
//      -> o_long_press after sample 8.
//      -> o_repeat after samples 12 and 16.
//      -> o_press_count increments by exactly 1.
//   4. Assert i_rst for 2 cycles with i_debounced=1, then hold high 20 more cycles.
//      -> all outputs 0 and no pulses.
//      Then drop low 1 cycle and press 2 samples -> one short pulse, o_press_count=1.
//   5. Five short presses -> o_press_count sequence 1,2,3,0,1.
//   6. REPEAT_LIMIT=0 instance, high 30 samples -> exactly one o_long_press, zero o_repeat.
//      Also drive a Debounce_Filter (DEBOUNCE_LIMIT=4) chained in front with a 1-cycle glitch.
//      -> single short press classified.

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// Shared types and helpers for the button press classifier.
// The state encoding covers all four values of the 2-bit enum.
package button_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2,
    LONG = 2'd3
  } press_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_classifier_hold_timer.sv
// Saturating up-counter with synchronous clear and increment enable.
// The owning FSM performs all terminal-value compares on o_count.
module hold_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short or long, emits auto-repeat pulses
// while a long press is held, and counts classified presses. All outputs are registered.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_LIMIT   = 25_000_000,
  parameter int REPEAT_LIMIT = 5_000_000,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_debounced,
  output logic                   o_short_press,
  output logic                   o_long_press,
  output logic                   o_repeat,
  output logic                   o_held,
  output logic [COUNT_WIDTH-1:0] o_press_count
);

  localparam int              CNT_W       = $clog2(max_int(LONG_LIMIT, REPEAT_LIMIT) + 1);
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'((REPEAT_LIMIT > 0) ? REPEAT_LIMIT - 1 : 0);
  localparam bit              REPEAT_EN   = (REPEAT_LIMIT != 0);

  press_state_t r_state;
  press_state_t w_next_state;

  logic                   r_short_press;
  logic                   r_long_press;
  logic                   r_repeat;
  logic                   r_held;
  logic [COUNT_WIDTH-1:0] r_press_count;

  logic             w_short;
  logic             w_long;
  logic             w_repeat;
  logic             w_clear;
  logic             w_inc;
  logic [CNT_W-1:0] w_count;

  hold_timer #(
    .WIDTH(CNT_W)
  ) u_hold_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(w_clear),
    .i_inc  (w_inc),
    .o_count(w_count)
  );

  // The timer is kept at zero outside HELD/LONG, so the increment on the
  // IDLE->HELD edge lands it on 1 for the first high sample.
  always_comb begin
    w_next_state = r_state;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      ARM: begin
        w_clear = 1'b1;
        if (!i_debounced) w_next_state = IDLE;
      end
      IDLE: begin
        if (i_debounced) begin
          w_next_state = HELD;
          w_inc        = 1'b1;
        end else begin
          w_clear = 1'b1;
        end
      end
      HELD: begin
        if (!i_debounced) begin
          w_next_state = IDLE;
          w_short      = 1'b1;
          w_clear      = 1'b1;
        end else if (w_count == LONG_TERM) begin
          w_next_state = LONG;
          w_long       = 1'b1;
          w_clear      = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      LONG: begin
        if (!i_debounced) begin
          w_next_state = IDLE;
          w_clear      = 1'b1;
        end else if (REPEAT_EN && (w_count == REPEAT_TERM)) begin
          w_repeat = 1'b1;
          w_clear  = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: begin
        w_next_state = ARM;
        w_clear      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ARM;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
      r_repeat      <= 1'b0;
      r_held        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_next_state;
      r_short_press <= w_short;
      r_long_press  <= w_long;
      r_repeat      <= w_repeat;
      r_held        <= (w_next_state == HELD) || (w_next_state == LONG);
      if (w_short || w_long) begin
        r_press_count <= r_press_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign o_short_press = r_short_press;
  assign o_long_press  = r_long_press;
  assign o_repeat      = r_repeat;
  assign o_held        = r_held;
  assign o_press_count = r_press_count;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier: one repeating instance driven directly,
// and one repeat-disabled instance fed through a behavioural debounce filter.
module tb_button_press_classifier;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic rst;
  logic deb;
  logic shortP, longP, rep, held;
  logic [1:0] cnt;

  logic dbRaw;
  logic dbOut;
  logic [1:0] dbCnt;
  logic shortP2, longP2, rep2, held2;
  logic [1:0] cnt2;

  int testsRun = 0;
  int testsFailed = 0;

  wire logic [5:0] outVec = {shortP, longP, rep, held, cnt};

  button_press_classifier #(
    .LONG_LIMIT(8), .REPEAT_LIMIT(4), .COUNT_WIDTH(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_debounced(deb),
    .o_short_press(shortP), .o_long_press(longP), .o_repeat(rep),
    .o_held(held), .o_press_count(cnt)
  );

  button_press_classifier #(
    .LONG_LIMIT(8), .REPEAT_LIMIT(0), .COUNT_WIDTH(2)
  ) dutNoRep (
    .i_clk(clk), .i_rst(rst), .i_debounced(dbOut),
    .o_short_press(shortP2), .o_long_press(longP2), .o_repeat(rep2),
    .o_held(held2), .o_press_count(cnt2)
  );

  // Behavioural debounce filter with a limit of 4 stable samples.
  always @(posedge clk) begin
    if (rst) begin
      dbOut <= 1'b0;
      dbCnt <= 2'd0;
    end else if (dbRaw != dbOut && dbCnt < 2'd3) begin
      dbCnt <= dbCnt + 2'd1;
    end else if (dbCnt == 2'd3) begin
      dbOut <= dbRaw;
      dbCnt <= 2'd0;
    end else begin
      dbCnt <= 2'd0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    deb = 1'b0;
    dbRaw = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    deb = 1'b0;
    dbRaw = 1'b0;
    step();
    step();
    testsRun++;
    if (outVec !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got %b want 000000", outVec);
    end
    testsRun++;
    if ({shortP2, longP2, rep2, held2, cnt2} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_norep got %b want 000000", {shortP2, longP2, rep2, held2, cnt2});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_short_press();
    logic [5:0] exp;
    doReset();
    for (int i = 0; i < 3; i++) begin
      step();
      testsRun++;
      if (outVec !== 6'b000000) begin
        testsFailed++;
        $display("[TB] FAIL short_idle cyc %0d got %b want 000000", i, outVec);
      end
    end
    deb = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = 6'b000100;
      testsRun++;
      if (outVec !== exp) begin
        testsFailed++;
        $display("[TB] FAIL short_held sample %0d got %b want %b", i, outVec, exp);
      end
    end
    deb = 1'b0;
    step();
    testsRun++;
    if (outVec !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL short_pulse got %b want 100001", outVec);
    end
    step();
    testsRun++;
    if (outVec !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL short_after got %b want 000001", outVec);
    end
  endtask

  task automatic test_long_press();
    logic [5:0] exp;
    doReset();
    deb = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      testsRun++;
      if (outVec !== 6'b000100) begin
        testsFailed++;
        $display("[TB] FAIL long7_held sample %0d got %b want 000100", i, outVec);
      end
    end
    deb = 1'b0;
    step();
    testsRun++;
    if (outVec !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL long7_short got %b want 100001", outVec);
    end
    deb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i == 8) ? 6'b010110 : 6'b000101;
      testsRun++;
      if (outVec !== exp) begin
        testsFailed++;
        $display("[TB] FAIL long8 sample %0d got %b want %b", i, outVec, exp);
      end
    end
    deb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      testsRun++;
      if (outVec !== 6'b000010) begin
        testsFailed++;
        $display("[TB] FAIL long8_release cyc %0d got %b want 000010", i, outVec);
      end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] exp;
    doReset();
    deb = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 8) exp = 6'b000100;
      else if (i == 8) exp = 6'b010101;
      else if (i == 12 || i == 16) exp = 6'b001101;
      else exp = 6'b000101;
      testsRun++;
      if (outVec !== exp) begin
        testsFailed++;
        $display("[TB] FAIL repeat sample %0d got %b want %b", i, outVec, exp);
      end
    end
    deb = 1'b0;
    step();
    testsRun++;
    if (outVec !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL repeat_release got %b want 000001", outVec);
    end
  endtask

  task automatic test_reset_while_held();
    doReset();
    deb = 1'b1;
    step();
    step();
    deb = 1'b0;
    step();
    testsRun++;
    if (outVec !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL rsthold_pre got %b want 100001", outVec);
    end
    deb = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      testsRun++;
      if (outVec !== 6'b000000) begin
        testsFailed++;
        $display("[TB] FAIL rsthold_in_reset cyc %0d got %b want 000000", i, outVec);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      testsRun++;
      if (outVec !== 6'b000000) begin
        testsFailed++;
        $display("[TB] FAIL rsthold_armed cyc %0d got %b want 000000", i, outVec);
      end
    end
    deb = 1'b0;
    step();
    deb = 1'b1;
    step();
    step();
    testsRun++;
    if (outVec !== 6'b000100) begin
      testsFailed++;
      $display("[TB] FAIL rsthold_press got %b want 000100", outVec);
    end
    deb = 1'b0;
    step();
    testsRun++;
    if (outVec !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL rsthold_short got %b want 100001", outVec);
    end
  endtask

  task automatic test_count_wrap();
    logic [1:0] expCnt;
    doReset();
    for (int p = 0; p < 5; p++) begin
      deb = 1'b1;
      step();
      deb = 1'b0;
      step();
      expCnt = 2'((p + 1) % 4);
      testsRun++;
      if (outVec !== {4'b1000, expCnt}) begin
        testsFailed++;
        $display("[TB] FAIL count_wrap press %0d got %b want %b", p, outVec, {4'b1000, expCnt});
      end
      step();
    end
  endtask

  task automatic test_no_repeat();
    int longs, reps, shorts, helds;
    doReset();
    longs = 0; reps = 0; shorts = 0;
    dbRaw = 1'b1;
    for (int i = 0; i < 44; i++) begin
      if (i == 34) dbRaw = 1'b0;
      step();
      longs += int'(longP2);
      reps += int'(rep2);
      shorts += int'(shortP2);
    end
    testsRun++;
    if (longs !== 1 || reps !== 0 || shorts !== 0) begin
      testsFailed++;
      $display("[TB] FAIL norep_pulses got long=%0d rep=%0d short=%0d want 1 0 0", longs, reps, shorts);
    end
    testsRun++;
    if (cnt2 !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL norep_count got %0d want 1", cnt2);
    end
    helds = 0; shorts = 0;
    dbRaw = 1'b1;
    step();
    dbRaw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      helds += int'(held2);
      shorts += int'(shortP2);
    end
    testsRun++;
    if (helds !== 0 || shorts !== 0) begin
      testsFailed++;
      $display("[TB] FAIL glitch_rejected got held=%0d short=%0d want 0 0", helds, shorts);
    end
    longs = 0; shorts = 0;
    dbRaw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) dbRaw = 1'b0;
      step();
      longs += int'(longP2);
      shorts += int'(shortP2);
    end
    testsRun++;
    if (shorts !== 1 || longs !== 0 || cnt2 !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL debounced_short got short=%0d long=%0d count=%0d want 1 0 2", shorts, longs, cnt2);
    end
  endtask

  initial begin
    rst = 1'b1;
    deb = 1'b0;
    dbRaw = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_repeat();
    test_reset_while_held();
    test_count_wrap();
    test_no_repeat();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
